// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller: stall-cause codes,
// FSM state encodings and the hard-wired zero register index.
package hazard_pkg;

    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [2:0] {
        CAUSE_NONE   = 3'd0,
        CAUSE_LOAD   = 3'd1,
        CAUSE_BRANCH = 3'd2,
        CAUSE_MDU    = 3'd3,
        CAUSE_DMEM   = 3'd4
    } stall_cause_e;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } haz_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the ID-stage pipeline signals and the hazard/stall controller.
//   master : pipeline side, drives hazard sources, receives stall controls
//   slave  : controller side
// REG_AW and CNT_W must match the parameters of the attached controller.
interface hazard_stall_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) ();
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_branch;
    logic              id_use_hilo;
    logic              ex_mem_read;
    logic              ex_reg_write;
    logic [REG_AW-1:0] ex_dst;
    logic              mem_mem_read;
    logic [REG_AW-1:0] mem_dst;
    logic              mdu_start;
    logic              dmem_wait;

    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_flush;
    logic              pipe_freeze;
    logic [2:0]        stall_cause;
    logic [CNT_W-1:0]  perf_stalls;
    logic [CNT_W-1:0]  perf_loaduse;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_use_hilo,
               ex_mem_read, ex_reg_write, ex_dst, mem_mem_read, mem_dst,
               mdu_start, dmem_wait,
        input  pc_write, if_id_write, id_ex_flush, pipe_freeze, stall_cause,
               perf_stalls, perf_loaduse
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_use_hilo,
               ex_mem_read, ex_reg_write, ex_dst, mem_mem_read, mem_dst,
               mdu_start, dmem_wait,
        output pc_write, if_id_write, id_ex_flush, pipe_freeze, stall_cause,
               perf_stalls, perf_loaduse
    );
endinterface

// File: rtl/stall_counter.sv
// Saturating down-counter used for load-use and MUL/DIV busy tracking.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   load       : load load_val (wins over dec)
//   load_val   : value to load
//   dec        : decrement by one, stops at zero; otherwise hold
//   zero_c     : count is zero (combinational)
module stall_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage MIPS core. Detects multi-cycle
// load-use, branch-in-ID dependencies, MUL/DIV busy and data-memory waits and
// drives PC / IF/ID hold, ID/EX flush and a global freeze with zero latency.
//   clk, rst_n : clock, async active-low reset
//   bus        : hazard_stall_ctrl_if.slave (hazard sources in, stall controls
//                and performance counters out)
// Optional feature: define HAZ_PERF_CNT_EN to build saturating performance
// counters; otherwise perf outputs are tied to zero.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MDU_LAT  = 4,
    parameter int unsigned CNT_W    = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_stall_ctrl_if.slave bus
);
    localparam int unsigned LCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam int unsigned MCW = $clog2(MDU_LAT + 1);

    haz_state_e   state;
    stall_cause_e cause;
    logic         hit_ex;
    logic         hit_mem;
    logic         load_hit;
    logic         br_hit;
    logic         load_wait;
    logic         new_load;
    logic         load_zero;
    logic         mdu_zero;

    // A source operand depends on dst only if it is really read and dst is not $0.
    function automatic logic src_hit(input logic use_s,
                                     input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst);
        return use_s && (src == dst) && (dst != REG_AW'(REG_ZERO));
    endfunction

    assign hit_ex   = src_hit(bus.id_use_rs, bus.id_rs, bus.ex_dst) |
                      src_hit(bus.id_use_rt, bus.id_rt, bus.ex_dst);
    assign hit_mem  = src_hit(bus.id_use_rs, bus.id_rs, bus.mem_dst) |
                      src_hit(bus.id_use_rt, bus.id_rt, bus.mem_dst);
    assign load_hit = bus.ex_mem_read & hit_ex;
    assign br_hit   = bus.id_branch &
                      ((bus.ex_reg_write & hit_ex) | (bus.mem_mem_read & hit_mem));

    // Remaining load bubbles are owed; new detections only count outside that window.
    assign load_wait = (state == LOAD_WAIT) && !load_zero;
    assign new_load  = !bus.dmem_wait && !load_wait && load_hit;

    stall_counter #(.W(LCW)) u_load_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (new_load),
        .load_val (LCW'(LOAD_LAT - 1)),
        .dec      (!bus.dmem_wait && load_wait),
        .zero_c   (load_zero)
    );

    // MUL/DIV busy keeps counting through freezes; a new issue restarts it.
    stall_counter #(.W(MCW)) u_mdu_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bus.mdu_start),
        .load_val (MCW'(MDU_LAT)),
        .dec      (1'b1),
        .zero_c   (mdu_zero)
    );

    // Load-use FSM; frozen cycles hold it in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (!bus.dmem_wait) begin
            if (new_load) begin
                state <= LOAD_WAIT;
            end else if ((state == LOAD_WAIT) && load_zero) begin
                state <= IDLE;
            end
        end
    end

    // Priority arbitration: dmem > load > branch > mdu.
    always_comb begin
        cause = CAUSE_NONE;
        if (bus.dmem_wait) begin
            cause = CAUSE_DMEM;
        end else if (load_wait || load_hit) begin
            cause = CAUSE_LOAD;
        end else if (br_hit) begin
            cause = CAUSE_BRANCH;
        end else if (!mdu_zero && bus.id_use_hilo) begin
            cause = CAUSE_MDU;
        end
    end

    // Control outputs; forced to run-state while reset is asserted.
    always_comb begin
        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        bus.id_ex_flush = 1'b0;
        bus.pipe_freeze = 1'b0;
        bus.stall_cause = 3'(CAUSE_NONE);
        if (rst_n) begin
            bus.pc_write    = (cause == CAUSE_NONE);
            bus.if_id_write = (cause == CAUSE_NONE);
            bus.id_ex_flush = (cause != CAUSE_NONE) && (cause != CAUSE_DMEM);
            bus.pipe_freeze = (cause == CAUSE_DMEM);
            bus.stall_cause = 3'(cause);
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stalls_q;
    logic [CNT_W-1:0] perf_loaduse_q;

    // Saturating stall-cycle and load-use event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stalls_q  <= '0;
            perf_loaduse_q <= '0;
        end else begin
            if ((cause != CAUSE_NONE) && (perf_stalls_q != '1)) begin
                perf_stalls_q <= perf_stalls_q + CNT_W'(1);
            end
            if (new_load && (perf_loaduse_q != '1)) begin
                perf_loaduse_q <= perf_loaduse_q + CNT_W'(1);
            end
        end
    end

    assign bus.perf_stalls  = perf_stalls_q;
    assign bus.perf_loaduse = perf_loaduse_q;
`else
    assign bus.perf_stalls  = CNT_W'(0);
    assign bus.perf_loaduse = CNT_W'(0);
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3) share
// the same stimulus and are compared against a cycle-level reference model.
module tb_hazard_stall_ctrl;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned MDU_LAT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [REG_AW-1:0] id_rs, id_rt, ex_dst, mem_dst;
    logic id_use_rs, id_use_rt, id_branch, id_use_hilo;
    logic ex_mem_read, ex_reg_write, mem_mem_read, mdu_start, dmem_wait;

    hazard_stall_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus1 ();
    hazard_stall_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus3 ();

    assign bus1.id_rs = id_rs;               assign bus3.id_rs = id_rs;
    assign bus1.id_rt = id_rt;               assign bus3.id_rt = id_rt;
    assign bus1.id_use_rs = id_use_rs;       assign bus3.id_use_rs = id_use_rs;
    assign bus1.id_use_rt = id_use_rt;       assign bus3.id_use_rt = id_use_rt;
    assign bus1.id_branch = id_branch;       assign bus3.id_branch = id_branch;
    assign bus1.id_use_hilo = id_use_hilo;   assign bus3.id_use_hilo = id_use_hilo;
    assign bus1.ex_mem_read = ex_mem_read;   assign bus3.ex_mem_read = ex_mem_read;
    assign bus1.ex_reg_write = ex_reg_write; assign bus3.ex_reg_write = ex_reg_write;
    assign bus1.ex_dst = ex_dst;             assign bus3.ex_dst = ex_dst;
    assign bus1.mem_mem_read = mem_mem_read; assign bus3.mem_mem_read = mem_mem_read;
    assign bus1.mem_dst = mem_dst;           assign bus3.mem_dst = mem_dst;
    assign bus1.mdu_start = mdu_start;       assign bus3.mdu_start = mdu_start;
    assign bus1.dmem_wait = dmem_wait;       assign bus3.dmem_wait = dmem_wait;

    hazard_stall_ctrl #(.REG_AW(REG_AW), .LOAD_LAT(1), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    hazard_stall_ctrl #(.REG_AW(REG_AW), .LOAD_LAT(3), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // {pc_write, if_id_write, id_ex_flush, pipe_freeze, stall_cause}
    logic [6:0]       obs_ctl [2];
    logic [CNT_W-1:0] obs_ps  [2];
    logic [CNT_W-1:0] obs_lu  [2];
    assign obs_ctl[0] = {bus1.pc_write, bus1.if_id_write, bus1.id_ex_flush, bus1.pipe_freeze, bus1.stall_cause};
    assign obs_ctl[1] = {bus3.pc_write, bus3.if_id_write, bus3.id_ex_flush, bus3.pipe_freeze, bus3.stall_cause};
    assign obs_ps[0]  = bus1.perf_stalls;
    assign obs_ps[1]  = bus3.perf_stalls;
    assign obs_lu[0]  = bus1.perf_loaduse;
    assign obs_lu[1]  = bus3.perf_loaduse;

    // Reference model state per instance.
    int lat       [2] = '{1, 3};
    int load_owed [2];
    int mdu_rem   [2];
    int m_ps      [2];
    int m_lu      [2];

    int n_assert = 0;
    int n_fail   = 0;

    function automatic bit hits(input logic [REG_AW-1:0] dst);
        return (dst != 0) && ((id_use_rs && id_rs == dst) || (id_use_rt && id_rt == dst));
    endfunction

    task automatic clr();
        id_rs = '0; id_rt = '0; ex_dst = '0; mem_dst = '0;
        id_use_rs = 0; id_use_rt = 0; id_branch = 0; id_use_hilo = 0;
        ex_mem_read = 0; ex_reg_write = 0; mem_mem_read = 0; mdu_start = 0; dmem_wait = 0;
    endtask

    // Check one cycle against the model, then advance to just after the next edge.
    task automatic step(input string tag);
        int               cause;
        bit               new_lu;
        logic [6:0]       exp_ctl;
        logic [CNT_W-1:0] exp_ps, exp_lu;
        #2;
        for (int k = 0; k < 2; k++) begin
            cause  = 0;
            new_lu = 0;
            if (!rst_n) begin
                load_owed[k] = 0; mdu_rem[k] = 0; m_ps[k] = 0; m_lu[k] = 0;
                exp_ctl = 7'b1100_000;
            end else begin
                if (dmem_wait) cause = 4;
                else if (load_owed[k] > 0) begin
                    cause = 1;
                    load_owed[k] = load_owed[k] - 1;
                end else if (ex_mem_read && hits(ex_dst)) begin
                    cause = 1;
                    load_owed[k] = lat[k] - 1;
                    new_lu = 1;
                end else if (id_branch && ((ex_reg_write && hits(ex_dst)) ||
                                           (mem_mem_read && hits(mem_dst)))) cause = 2;
                else if (mdu_rem[k] > 0 && id_use_hilo) cause = 3;
                exp_ctl = {cause == 0, cause == 0, cause >= 1 && cause <= 3, cause == 4, 3'(cause)};
            end
`ifdef HAZ_PERF_CNT_EN
            exp_ps = CNT_W'(m_ps[k]);
            exp_lu = CNT_W'(m_lu[k]);
`else
            exp_ps = '0;
            exp_lu = '0;
`endif
            n_assert++;
            assert (obs_ctl[k] === exp_ctl) else begin
                n_fail++;
                $error("FAIL %s lat%0d ctl: observed=%b expected=%b", tag, lat[k], obs_ctl[k], exp_ctl);
            end
            n_assert++;
            assert (obs_ps[k] === exp_ps) else begin
                n_fail++;
                $error("FAIL %s lat%0d perf_stalls: observed=%0d expected=%0d", tag, lat[k], obs_ps[k], exp_ps);
            end
            n_assert++;
            assert (obs_lu[k] === exp_lu) else begin
                n_fail++;
                $error("FAIL %s lat%0d perf_loaduse: observed=%0d expected=%0d", tag, lat[k], obs_lu[k], exp_lu);
            end
            if (rst_n) begin
                if (cause != 0 && m_ps[k] < 65535) m_ps[k]++;
                if (new_lu && m_lu[k] < 65535) m_lu[k]++;
                if (mdu_start) mdu_rem[k] = MDU_LAT;
                else if (mdu_rem[k] > 0) mdu_rem[k]--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        // Reset with a live load-use on the inputs: controls must stay released.
        ex_mem_read = 1; ex_reg_write = 1; ex_dst = 2; id_rs = 2; id_use_rs = 1;
        step("reset_a");
        step("reset_b");
        clr();
        rst_n = 1'b1;
        step("idle");

        // lw $2 in EX, add $3,$2,$4 in ID
        ex_mem_read = 1; ex_reg_write = 1; ex_dst = 2;
        id_rs = 2; id_rt = 4; id_use_rs = 1; id_use_rt = 1;
        step("lu_detect");
        ex_mem_read = 0; ex_reg_write = 0; ex_dst = 0; mem_mem_read = 1; mem_dst = 2;
        step("lu_hold1");
        mem_mem_read = 0; mem_dst = 0;
        step("lu_hold2");
        step("lu_release");
        clr();
        step("idle2");

        // lw $5 in EX, beq $5,$0 in ID
        id_branch = 1; id_rs = 5; id_rt = 0; id_use_rs = 1; id_use_rt = 1;
        ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5;
        step("lbr_load");
        ex_mem_read = 0; ex_reg_write = 0; ex_dst = 0; mem_mem_read = 1; mem_dst = 5;
        step("lbr_branch");
        mem_mem_read = 0; mem_dst = 0;
        step("lbr_w1");
        step("lbr_w2");
        clr();

        // lw $0 with consumer of $0
        ex_mem_read = 1; ex_reg_write = 1; ex_dst = 0; id_rs = 0; id_use_rs = 1;
        id_branch = 1; mem_mem_read = 1; mem_dst = 0;
        step("reg_zero");
        clr();

        // mdu_start then mfhi in ID
        mdu_start = 1;
        step("mdu_issue");
        mdu_start = 0; id_use_hilo = 1;
        for (int i = 0; i < 6; i++) step("mdu_busy");
        clr();
        step("idle3");

        // dmem_wait during load wait
        ex_mem_read = 1; ex_dst = 7; id_rt = 7; id_use_rt = 1;
        step("frz_detect");
        ex_mem_read = 0; ex_dst = 0; dmem_wait = 1;
        step("frz_1");
        step("frz_2");
        dmem_wait = 0;
        for (int i = 0; i < 3; i++) step("frz_resume");
        clr();

        // Reset mid-stall releases immediately
        ex_mem_read = 1; ex_dst = 3; id_rs = 3; id_use_rs = 1;
        step("rst_detect");
        clr();
        rst_n = 1'b0;
        step("rst_mid");
        rst_n = 1'b1;
        step("rst_after");

        // Randomized traffic with narrow register indices to force matches
        for (int i = 0; i < 400; i++) begin
            id_rs        = REG_AW'($urandom_range(0, 3));
            id_rt        = REG_AW'($urandom_range(0, 3));
            ex_dst       = REG_AW'($urandom_range(0, 3));
            mem_dst      = REG_AW'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom_range(0, 1));
            id_use_rt    = 1'($urandom_range(0, 1));
            id_branch    = ($urandom_range(0, 3) == 0);
            id_use_hilo  = ($urandom_range(0, 2) == 0);
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            ex_reg_write = 1'($urandom_range(0, 1));
            mem_mem_read = ($urandom_range(0, 3) == 0);
            mdu_start    = ($urandom_range(0, 7) == 0);
            dmem_wait    = ($urandom_range(0, 7) == 0);
            step("rand");
        end
        clr();
        step("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
